score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Clocked, parametrised game-score accumulator for the maze game logic.
//  Takes bonus/penalty/legal-move events from the move checker and applies at most one
//  score update per received move packet. Re-arms on each new packet strobe.
//  Saturates instead of wrapping; drives the score display and, optionally, a high-score tracker.
// PARAMETERS
//  WIDTH      8     score register width in bits
//  BONUS      5     amount added on plus_evt
//  PENALTY    5     amount subtracted on minus_evt
//  STEP       1     amount added on legal_evt
//  MAX_SCORE  255   upper clamp; must be <= 2**WIDTH-1
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  resetn       in   1      reset resetn, synchronous, active-low
//  clear        in   1      sync game restart; clears score and FSM, not hi_score
//  rx_strobe    in   1      move-packet received; rising edge re-arms updates
//  plus_evt     in   1      bonus event (level, sampled while ARMED)
//  minus_evt    in   1      penalty event
//  legal_evt    in   1      legal move event
//  score        out  WIDTH  current score
//  score_upd    out  1      1-cycle pulse when an update is applied
//  sat_hi       out  1      sticky: an add was clamped at MAX_SCORE
//  sat_lo       out  1      sticky: a subtract was clamped at 0
//  hi_score     out  WIDTH  best score this power-up (SCORE_HISCORE_EN only)
// BEHAVIOUR
//  - Reset (resetn=0 at posedge): score=0, score_upd=0, sat_hi=sat_lo=0, hi_score=0,
//    FSM=ARMED, rx_strobe edge-detect register=0.
//  - clear=1: same as reset except hi_score is kept; clear has priority over all events.
//  - FSM ARMED: first cycle with any event asserted applies one update; priority
//    plus_evt > minus_evt > legal_evt; lower-priority events that cycle are dropped.
//    FSM -> LOCKED on the same edge; score and score_upd=1 visible the next cycle (latency 1).
//  - FSM LOCKED: all events ignored. Rising edge of rx_strobe (rx_strobe & ~rx_q)
//    -> ARMED on the next edge. Events in the same cycle as that rising edge are ignored.
//  - ARMED with rx_strobe rising in the same cycle as an event: event is applied, FSM
//    -> LOCKED; the edge is consumed. No second update.
//  - rx_strobe held high: one re-arm only; a new rising edge is needed.
//  - Arithmetic in WIDTH+1 bits. Add: if score+amt > MAX_SCORE then score=MAX_SCORE, sat_hi=1.
//    Subtract: if score < PENALTY then score=0, sat_lo=1. Exactly at the bound is not saturation.
//  - sat_hi/sat_lo are sticky until reset or clear.
//  - Reset or clear mid-LOCKED returns the FSM to ARMED.
// CONFIGURATION
//  - SCORE_HISCORE_EN defined: hi_score register updates to the new score on the edge
//    after any update where new score > hi_score. Survives clear; zeroed only by resetn.
//  - SCORE_HISCORE_EN undefined: hi_score port tied to 0 and no register is built.
// STRUCTURE
//  - score_pkg: FSM state enum {ARMED, LOCKED}, event-select encoding {EV_NONE, EV_PLUS,
//    EV_MINUS, EV_LEGAL}, priority-encode function.
//  - Sub-module sat_addsub (WIDTH, MAX_SCORE): combinational clamp add/sub with sat flags.
//    It is instantiated once; the FSM and registers stay in score_keeper.
// TESTING
//  1 reset, ARMED, legal_evt 1 cycle -> score=1, score_upd pulse once; repeat legal_evt
//    with no rx_strobe -> score stays 1.
//  2 plus_evt+minus_evt+legal_evt same cycle from 10 -> score=15 only; rx_strobe
//    0->1, then minus_evt -> 10.
//  3 score=3, minus_evt -> score=0, sat_lo=1; score=252, plus_evt -> 255, sat_hi=1;
//    score=250, plus_evt -> 255, sat_hi stays 0 if previously clear.
//  4 LOCKED, rx_strobe rises with plus_evt same cycle -> no change, ARMED next; hold
//    rx_strobe high across two updates -> only first applied.
//  5 score=40 (hi_score=40), clear -> score=0, flags=0, hi_score=40; resetn -> hi_score=0.
//    Without the macro, hi_score=0 throughout.
//  6 resetn low while LOCKED with events active -> all outputs 0 next cycle, FSM ARMED.

Source files
------------

// File: rtl/score_pkg.sv
// Shared encodings for the score keeper: FSM state codes, event-select enum and
// the event priority encoder.
package score_pkg;

  localparam logic [0:0] ST_ARMED  = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_PLUS  = 2'd1,
    EV_MINUS = 2'd2,
    EV_LEGAL = 2'd3
  } ev_sel_t;

  // Bonus beats penalty beats legal move; the losers are dropped for this packet.
  function automatic ev_sel_t prio_encode(input logic plus_evt, input logic minus_evt,
                                          input logic legal_evt);
    if (plus_evt)       return EV_PLUS;
    else if (minus_evt) return EV_MINUS;
    else if (legal_evt) return EV_LEGAL;
    else                return EV_NONE;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Event inputs and score outputs of the score keeper.
// master drives the events (move checker side), slave is the score keeper.
interface score_keeper_if #(
  parameter int WIDTH = 8
);
  logic             rx_strobe;
  logic             plus_evt;
  logic             minus_evt;
  logic             legal_evt;
  logic [WIDTH-1:0] score;
  logic             score_upd;
  logic             sat_hi;
  logic             sat_lo;
  logic [WIDTH-1:0] hi_score;

  modport master (
    output rx_strobe, plus_evt, minus_evt, legal_evt,
    input  score, score_upd, sat_hi, sat_lo, hi_score
  );

  modport slave (
    input  rx_strobe, plus_evt, minus_evt, legal_evt,
    output score, score_upd, sat_hi, sat_lo, hi_score
  );
endinterface

// File: rtl/score_keeper_sat_addsub.sv
// Combinational clamped add/subtract: adds clamp at MAX_SCORE, subtracts clamp at 0;
// sat flags a clamp. Landing exactly on a bound is not a clamp.
module sat_addsub #(
  parameter int WIDTH     = 8,
  parameter int MAX_SCORE = 255
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amt,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             sat
);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_SCORE);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, amt};
    result = sum[WIDTH-1:0];
    sat    = 1'b0;
    if (sub) begin
      if (a < amt) begin
        result = '0;
        sat    = 1'b1;
      end else begin
        result = a - amt;
      end
    end else if (sum > MAX_W) begin
      result = MAX_W[WIDTH-1:0];
      sat    = 1'b1;
    end
  end
endmodule

// File: rtl/score_keeper.sv
// Game score accumulator: one saturating update per move packet, re-armed by a
// rising edge of rx_strobe. Optional high-score register under SCORE_HISCORE_EN.
//
// state     | meaning
// ST_ARMED  | waiting for the first event of this packet
// ST_LOCKED | update done; ignoring events until rx_strobe rises
module score_keeper
  import score_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BONUS     = 5,
  parameter int PENALTY   = 5,
  parameter int STEP      = 1,
  parameter int MAX_SCORE = 255
) (
  input logic          clk,
  input logic          resetn,
  input logic          clear,
  score_keeper_if.slave bus
);
  logic [0:0]       state;
  logic             rx_q;
  logic [WIDTH-1:0] score_q;
  logic             score_upd_q;
  logic             sat_hi_q;
  logic             sat_lo_q;

  ev_sel_t          ev;
  logic [WIDTH-1:0] amt;
  logic             sub;
  logic [WIDTH-1:0] nxt;
  logic             sat;
  logic             rx_rise;

  assign rx_rise = bus.rx_strobe & ~rx_q;

  always_comb begin
    ev  = prio_encode(bus.plus_evt, bus.minus_evt, bus.legal_evt);
    amt = '0;
    sub = 1'b0;
    case (ev)
      EV_PLUS:  amt = WIDTH'(BONUS);
      EV_MINUS: begin
        amt = WIDTH'(PENALTY);
        sub = 1'b1;
      end
      EV_LEGAL: amt = WIDTH'(STEP);
      default:  amt = '0;
    endcase
  end

  sat_addsub #(
    .WIDTH     (WIDTH),
    .MAX_SCORE (MAX_SCORE)
  ) u_sat_addsub (
    .a      (score_q),
    .amt    (amt),
    .sub    (sub),
    .result (nxt),
    .sat    (sat)
  );

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      state       <= ST_ARMED;
      rx_q        <= 1'b0;
      score_q     <= '0;
      score_upd_q <= 1'b0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
    end else begin
      rx_q        <= bus.rx_strobe;
      score_upd_q <= 1'b0;
      if (state == ST_ARMED) begin
        // An rx_strobe edge arriving with the event is absorbed by this update.
        if (ev != EV_NONE) begin
          score_q     <= nxt;
          score_upd_q <= 1'b1;
          state       <= ST_LOCKED;
          if (sat && sub)  sat_lo_q <= 1'b1;
          if (sat && !sub) sat_hi_q <= 1'b1;
        end
      end else if (rx_rise) begin
        state <= ST_ARMED;
      end
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [WIDTH-1:0] hi_q;

  // Follows the registered score, so it lands one edge after the update; clear leaves it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
    end else if (score_upd_q && (score_q > hi_q)) begin
      hi_q <= score_q;
    end
  end

  assign bus.hi_score = hi_q;
`else
  assign bus.hi_score = '0;
`endif

  assign bus.score     = score_q;
  assign bus.score_upd = score_upd_q;
  assign bus.sat_hi    = sat_hi_q;
  assign bus.sat_lo    = sat_lo_q;
endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table plus hand-written saturation,
// clear and high-score sequences, checked through a one-cycle-latency scoreboard.
module tb_score_keeper;
  logic clk;
  logic resetn;
  logic clear;

  score_keeper_if #(.WIDTH(8)) bus ();

  score_keeper #(
    .WIDTH     (8),
    .BONUS     (5),
    .PENALTY   (5),
    .STEP      (1),
    .MAX_SCORE (255)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] score;
    logic       upd;
    logic       shi;
    logic       slo;
    logic [7:0] hs;
  } exp_t;

  typedef struct {
    logic rstn;
    logic clr;
    logic rx;
    logic p;
    logic m;
    logic l;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] hs_m;

  function automatic logic [7:0] hsx(input logic [7:0] v);
`ifdef SCORE_HISCORE_EN
    return v;
`else
    return v & 8'h00;
`endif
  endfunction

  task automatic chk(input string tag, input string fld, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s %s got %0d want %0d", tag, fld, got, want);
    end
  endtask

  task automatic cyc(input string tag, input logic rstn_i, input logic clr_i, input logic rx_i,
                     input logic p_i, input logic m_i, input logic l_i, input exp_t e);
    exp_t x;
    resetn        = rstn_i;
    clear         = clr_i;
    bus.rx_strobe = rx_i;
    bus.plus_evt  = p_i;
    bus.minus_evt = m_i;
    bus.legal_evt = l_i;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk(tag, "score",     int'(bus.score),     int'(x.score));
    chk(tag, "score_upd", int'(bus.score_upd), int'(x.upd));
    chk(tag, "sat_hi",    int'(bus.sat_hi),    int'(x.shi));
    chk(tag, "sat_lo",    int'(bus.sat_lo),    int'(x.slo));
    chk(tag, "hi_score",  int'(bus.hi_score),  int'(hsx(x.hs)));
  endtask

  task automatic av(input logic rstn_i, input logic clr_i, input logic rx_i, input logic p_i,
                    input logic m_i, input logic l_i, input logic [7:0] s, input logic u,
                    input logic shi, input logic slo, input logic [7:0] hs);
    vec_t v;
    v.rstn = rstn_i; v.clr = clr_i; v.rx = rx_i; v.p = p_i; v.m = m_i; v.l = l_i;
    v.e.score = s; v.e.upd = u; v.e.shi = shi; v.e.slo = slo; v.e.hs = hs;
    tbl.push_back(v);
  endtask

  task automatic do_reset(input string tag);
    exp_t e;
    e.score = 0; e.upd = 0; e.shi = 0; e.slo = 0; e.hs = 0;
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    hs_m = 8'd0;
  endtask

  // One applied event followed by a re-arm cycle (rx_strobe rising).
  task automatic upd(input string tag, input logic p_i, input logic m_i, input logic l_i,
                     input logic [7:0] s, input logic shi, input logic slo);
    exp_t e;
    e.score = s; e.upd = 1'b1; e.shi = shi; e.slo = slo; e.hs = hs_m;
    cyc(tag, 1'b1, 1'b0, 1'b0, p_i, m_i, l_i, e);
    if (s > hs_m) hs_m = s;
    e.upd = 1'b0; e.hs = hs_m;
    cyc({tag, "_rearm"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e);
  endtask

  initial begin
    exp_t e;
    resetn = 1'b0; clear = 1'b0;
    bus.rx_strobe = 1'b0; bus.plus_evt = 1'b0; bus.minus_evt = 1'b0; bus.legal_evt = 1'b0;

    //  rstn clr rx p  m  l   score upd shi slo hs
    av(0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0);
    av(1, 0, 0, 0, 0, 1,   1, 1, 0, 0,  0);
    av(1, 0, 0, 0, 0, 1,   1, 0, 0, 0,  1);
    av(1, 0, 0, 0, 0, 1,   1, 0, 0, 0,  1);
    av(0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0);
    av(1, 0, 0, 1, 0, 0,   5, 1, 0, 0,  0);
    av(1, 0, 1, 0, 0, 0,   5, 0, 0, 0,  5);
    av(1, 0, 0, 1, 0, 0,  10, 1, 0, 0,  5);
    av(1, 0, 1, 0, 0, 0,  10, 0, 0, 0, 10);
    av(1, 0, 0, 1, 1, 1,  15, 1, 0, 0, 10);
    av(1, 0, 1, 0, 0, 0,  15, 0, 0, 0, 15);
    av(1, 0, 0, 0, 1, 0,  10, 1, 0, 0, 15);
    av(1, 0, 1, 1, 0, 0,  10, 0, 0, 0, 15);
    av(1, 0, 1, 1, 0, 0,  15, 1, 0, 0, 15);
    av(1, 0, 1, 1, 0, 0,  15, 0, 0, 0, 15);
    av(1, 0, 1, 1, 0, 0,  15, 0, 0, 0, 15);
    av(1, 0, 0, 0, 0, 0,  15, 0, 0, 0, 15);
    av(1, 0, 1, 0, 0, 0,  15, 0, 0, 0, 15);
    av(1, 0, 0, 0, 0, 0,  15, 0, 0, 0, 15);
    av(1, 0, 1, 0, 0, 1,  16, 1, 0, 0, 15);
    av(1, 0, 1, 0, 0, 0,  16, 0, 0, 0, 16);
    av(1, 0, 0, 0, 0, 0,  16, 0, 0, 0, 16);
    av(1, 0, 0, 0, 0, 1,  16, 0, 0, 0, 16);
    av(1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 16);
    av(1, 0, 0, 1, 0, 0,   5, 1, 0, 0, 16);
    av(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 16);
    av(1, 0, 0, 0, 1, 0,   0, 1, 0, 1, 16);
    av(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 16);
    av(1, 0, 0, 0, 0, 1,   1, 1, 0, 0, 16);
    av(0, 0, 1, 1, 1, 1,   0, 0, 0, 0,  0);
    av(1, 0, 0, 0, 0, 1,   1, 1, 0, 0,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].rstn, tbl[i].clr, tbl[i].rx,
          tbl[i].p, tbl[i].m, tbl[i].l, tbl[i].e);
    end

    // Subtract below zero from 3, sat_lo sticky, then clear drops the flag.
    do_reset("lo_rst");
    upd("lo_l1", 0, 0, 1, 8'd1, 0, 0);
    upd("lo_l2", 0, 0, 1, 8'd2, 0, 0);
    upd("lo_l3", 0, 0, 1, 8'd3, 0, 0);
    upd("lo_sat", 0, 1, 0, 8'd0, 0, 1);
    upd("lo_sticky", 0, 0, 1, 8'd1, 0, 1);
    e.score = 0; e.upd = 0; e.shi = 0; e.slo = 0; e.hs = hs_m;
    cyc("lo_clear", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e);

    // 250 + 5 lands exactly on the bound; the following add clamps.
    do_reset("hi_rst");
    for (int i = 0; i < 50; i++) upd($sformatf("hi_p%0d", i), 1, 0, 0, 8'(5 * (i + 1)), 0, 0);
    upd("hi_exact", 1, 0, 0, 8'd255, 0, 0);
    upd("hi_sat", 0, 0, 1, 8'd255, 1, 0);
    upd("hi_sticky", 0, 1, 0, 8'd250, 1, 0);

    // 252 + 5 clamps to 255.
    do_reset("h2_rst");
    for (int i = 0; i < 50; i++) upd($sformatf("h2_p%0d", i), 1, 0, 0, 8'(5 * (i + 1)), 0, 0);
    upd("h2_l1", 0, 0, 1, 8'd251, 0, 0);
    upd("h2_l2", 0, 0, 1, 8'd252, 0, 0);
    upd("h2_sat", 1, 0, 0, 8'd255, 1, 0);

    // High score survives clear, not resetn.
    do_reset("hs_rst");
    for (int i = 0; i < 8; i++) upd($sformatf("hs_p%0d", i), 1, 0, 0, 8'(5 * (i + 1)), 0, 0);
    e.score = 0; e.upd = 0; e.shi = 0; e.slo = 0; e.hs = 8'd40;
    cyc("hs_clear", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, e);
    e.hs = 8'd40;
    cyc("hs_after_clear", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e);
    do_reset("hs_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
